// File: rtl/oled_i2c_pkg.sv
// Shared encodings and byte-class helpers for the SSD1306-style I2C receive path.
package oled_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_CTRL,
    ST_ACK_CTRL,
    ST_PAYLOAD,
    ST_ACK_PAYLOAD,
    ST_IGNORE
  } state_t;

  localparam int          CTRL_CO_BIT     = 7;
  localparam int          CTRL_DC_BIT     = 6;
  localparam logic [7:0]  CMD_PAGE_BASE   = 8'hB0;
  localparam logic [7:0]  CMD_COL_LO_BASE = 8'h00;
  localparam logic [7:0]  CMD_COL_HI_BASE = 8'h10;
  localparam logic [6:0]  DEFAULT_ADDR    = 7'h3C;

  function automatic logic is_page_cmd(input logic [7:0] b);
    return b[7:3] == CMD_PAGE_BASE[7:3];
  endfunction

  function automatic logic is_col_lo_cmd(input logic [7:0] b);
    return b[7:4] == CMD_COL_LO_BASE[7:4];
  endfunction

  function automatic logic is_col_hi_cmd(input logic [7:0] b);
    return b[7:3] == CMD_COL_HI_BASE[7:3];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser on scl/sda plus a previous-value stage for edge and
// START/STOP event detection.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_p;
  logic       sda_p;
  logic       scl_s;

  // Reset to the idle-bus level so leaving reset never looks like an event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_p  <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda_in};
      scl_p  <= scl_ff[1];
      sda_p  <= sda_ff[1];
    end
  end

  assign scl_s    = scl_ff[1];
  assign sda_s    = sda_ff[1];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start    = scl_s & scl_p & sda_p & ~sda_s;
  assign stop     = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/oled_i2c_responder.sv
// Write-only I2C target decoding an SSD1306-style stream into GDDRAM write
// strobes and pass-through command strobes, tracking the page/column pointer.
//
// state          | meaning
// ST_IDLE        | bus free, waiting for START
// ST_ADDR        | shifting address + R/W byte
// ST_ACK_ADDR    | driving ACK for our address
// ST_CTRL        | shifting control byte (Co, D/C)
// ST_ACK_CTRL    | driving ACK for control byte
// ST_PAYLOAD     | shifting command/data byte
// ST_ACK_PAYLOAD | driving ACK for payload byte
// ST_IGNORE      | not addressed (or read), wait for START/STOP
module oled_i2c_responder
  import oled_i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_ADDR,
  parameter int         COLS       = 128,
  parameter int         PAGES      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_en,
  output logic [2:0] wr_page,
  output logic [6:0] wr_col,
  output logic [7:0] wr_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte
);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [6:0] shreg, shreg_nxt;
  logic       ack_ph, ack_ph_nxt;
  logic       co, co_nxt;
  logic       dc, dc_nxt;
  logic       sda_oe_nxt, busy_nxt, wr_en_nxt, cmd_valid_nxt;
  logic [2:0] wr_page_nxt;
  logic [6:0] wr_col_nxt;
  logic [7:0] wr_data_nxt, cmd_byte_nxt;
  logic [7:0] rx_byte;

  assign rx_byte = {shreg, sda_s};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      ack_ph    <= 1'b0;
      co        <= 1'b0;
      dc        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_page   <= 3'd0;
      wr_col    <= 7'd0;
      wr_data   <= 8'd0;
      cmd_valid <= 1'b0;
      cmd_byte  <= 8'd0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      ack_ph    <= ack_ph_nxt;
      co        <= co_nxt;
      dc        <= dc_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      wr_en     <= wr_en_nxt;
      wr_page   <= wr_page_nxt;
      wr_col    <= wr_col_nxt;
      wr_data   <= wr_data_nxt;
      cmd_valid <= cmd_valid_nxt;
      cmd_byte  <= cmd_byte_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    ack_ph_nxt    = ack_ph;
    co_nxt        = co;
    dc_nxt        = dc;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy;
    wr_en_nxt     = 1'b0;
    wr_page_nxt   = wr_page;
    wr_col_nxt    = wr_col;
    wr_data_nxt   = wr_data;
    cmd_valid_nxt = 1'b0;
    cmd_byte_nxt  = cmd_byte;

    // Column advances the cycle after the write strobe that used it.
    if (wr_en)
      wr_col_nxt = (wr_col == 7'(COLS - 1)) ? 7'd0 : wr_col + 7'd1;

    if (start) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = 3'd0;
      ack_ph_nxt  = 1'b0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b1;
    end else if (stop) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = 3'd0;
      ack_ph_nxt  = 1'b0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_CTRL, ST_PAYLOAD: begin
          if (scl_rise) begin
            shreg_nxt   = rx_byte[6:0];
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR) begin
                state_nxt = (rx_byte[7:1] == SLAVE_ADDR && !rx_byte[0]) ? ST_ACK_ADDR : ST_IGNORE;
              end else if (state == ST_CTRL) begin
                co_nxt    = rx_byte[CTRL_CO_BIT];
                dc_nxt    = rx_byte[CTRL_DC_BIT];
                state_nxt = ST_ACK_CTRL;
              end else begin
                state_nxt = ST_ACK_PAYLOAD;
                if (dc) begin
                  wr_en_nxt   = 1'b1;
                  wr_data_nxt = rx_byte;
                end else if (is_page_cmd(rx_byte)) begin
                  if (int'(rx_byte[2:0]) < PAGES)
                    wr_page_nxt = rx_byte[2:0];
                end else if (is_col_lo_cmd(rx_byte)) begin
                  wr_col_nxt[3:0] = rx_byte[3:0];
                end else if (is_col_hi_cmd(rx_byte)) begin
                  wr_col_nxt[6:4] = rx_byte[2:0];
                end else begin
                  cmd_valid_nxt = 1'b1;
                  cmd_byte_nxt  = rx_byte;
                end
              end
            end
          end
        end
        ST_ACK_ADDR, ST_ACK_CTRL, ST_ACK_PAYLOAD: begin
          // First falling edge starts the ACK bit, second one ends it.
          if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe_nxt = 1'b1;
              ack_ph_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              ack_ph_nxt  = 1'b0;
              bit_cnt_nxt = 3'd0;
              if (state == ST_ACK_ADDR)
                state_nxt = ST_CTRL;
              else if (state == ST_ACK_CTRL)
                state_nxt = ST_PAYLOAD;
              else
                state_nxt = co ? ST_CTRL : ST_PAYLOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_i2c_responder.sv
// Directed bench: bit-banged I2C master with wired-AND SDA, logging of write
// and command strobes against hand-computed expectations.
module tb_oled_i2c_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_drv;
  logic       sda_line;
  logic       sda_oe, busy, wr_en, cmd_valid;
  logic [2:0] wr_page;
  logic [6:0] wr_col;
  logic [7:0] wr_data, cmd_byte;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_pulses = 0;
  int acks;
  int base_pulses;
  logic a;
  logic oe_q = 1'b0;
  logic [17:0] wr_log[$];
  logic [7:0]  cmd_log[$];
  logic [7:0]  txq[$];

  always #5 clk = ~clk;

  assign sda_line = sda_drv & ~sda_oe;

  oled_i2c_responder dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_page   (wr_page),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte)
  );

  always @(negedge clk) begin
    if (wr_en) wr_log.push_back({wr_page, wr_col, wr_data});
    if (cmd_valid) cmd_log.push_back(cmd_byte);
    if (sda_oe && !oe_q) ack_pulses++;
    oe_q <= sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_clk(Q);
    scl     = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl     = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_drv = 1'b0;
    wait_clk(Q); scl     = 1'b1;
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      wait_clk(Q); sda_drv = b[i];
      wait_clk(Q); scl = 1'b1;
      wait_clk(2 * Q); scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); ack = sda_line;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic send_q(output int n_ack);
    logic ack;
    n_ack = 0;
    for (int i = 0; i < txq.size(); i++) begin
      send_byte(txq[i], ack);
      if (!ack) n_ack++;
    end
  endtask

  initial begin
    rst = 1'b0; scl = 1'b1; sda_drv = 1'b1;
    wait_clk(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_page", wr_page, 0);
    check("rst_col", wr_col, 0);
    check("rst_data", wr_data, 0);
    check("rst_cmd_byte", cmd_byte, 0);
    rst = 1'b1;
    wait_clk(5);

    // basic data write
    i2c_start();
    check("t1_busy", busy, 1);
    txq = {8'h78, 8'h40, 8'hAA, 8'h55};
    send_q(acks);
    check("t1_acks", acks, 4);
    check("t1_pulses", ack_pulses, 4);
    check("t1_nwr", wr_log.size(), 2);
    check("t1_wr0", wr_log[0], {3'd0, 7'd0, 8'hAA});
    check("t1_wr1", wr_log[1], {3'd0, 7'd1, 8'h55});
    check("t1_col", wr_col, 7'd2);
    wait_clk(Q); sda_drv = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(2);
    check("t1_busy_hold", busy, 1);
    wait_clk(1);
    check("t1_busy_drop", busy, 0);
    wait_clk(2 * Q);

    // pointer commands, then data at the new pointer
    i2c_start();
    txq = {8'h78, 8'h00, 8'hB3, 8'h05, 8'h12, 8'hAF};
    send_q(acks);
    i2c_stop();
    check("t2_acks", acks, 6);
    check("t2_nwr", wr_log.size(), 2);
    check("t2_ncmd", cmd_log.size(), 1);
    check("t2_cmd0", cmd_log[0], 8'hAF);
    check("t2_page", wr_page, 3'd3);
    check("t2_col", wr_col, 7'h25);
    i2c_start();
    txq = {8'h78, 8'h40, 8'hFF};
    send_q(acks);
    i2c_stop();
    check("t2_nwr2", wr_log.size(), 3);
    check("t2_wr2", wr_log[2], {3'd3, 7'h25, 8'hFF});

    // Co=1: control byte before every payload byte
    i2c_start();
    txq = {8'h78, 8'h80, 8'hB2, 8'hC0, 8'h11, 8'h80, 8'hB5};
    send_q(acks);
    i2c_stop();
    check("t3_acks", acks, 7);
    check("t3_nwr", wr_log.size(), 4);
    check("t3_wr3", wr_log[3], {3'd2, 7'h26, 8'h11});
    check("t3_page", wr_page, 3'd5);
    check("t3_ncmd", cmd_log.size(), 1);

    // wrong address, then read: NACKed and silent
    base_pulses = ack_pulses;
    i2c_start();
    txq = {8'h7A, 8'h40, 8'h01};
    send_q(acks);
    check("t4_acks", acks, 0);
    check("t4_pulses", ack_pulses, base_pulses);
    check("t4_busy", busy, 1);
    i2c_stop();
    check("t4_nwr", wr_log.size(), 4);
    i2c_start();
    send_byte(8'h79, a);
    check("t4_read_nack", a, 1);
    wait_clk(4 * Q);
    check("t4_read_busy", busy, 1);
    i2c_stop();
    check("t4_read_idle", busy, 0);
    check("t4_read_pulses", ack_pulses, base_pulses);
    check("t4_read_nwr", wr_log.size(), 4);

    // column wrap
    i2c_start();
    txq = {8'h78, 8'h00, 8'h0F, 8'h17};
    send_q(acks);
    i2c_stop();
    check("t5_col", wr_col, 7'h7F);
    i2c_start();
    txq = {8'h78, 8'h40, 8'h01, 8'h02};
    send_q(acks);
    i2c_stop();
    check("t5_nwr", wr_log.size(), 6);
    check("t5_wr4", wr_log[4], {3'd5, 7'h7F, 8'h01});
    check("t5_wr5", wr_log[5], {3'd5, 7'h00, 8'h02});

    // repeated START after a partial data byte
    i2c_start();
    send_byte(8'h78, a);
    send_byte(8'h40, a);
    send_bits(8'hA5, 4);
    i2c_start();
    check("t6_no_wr", wr_log.size(), 6);
    txq = {8'h78, 8'h40, 8'h33};
    send_q(acks);
    i2c_stop();
    check("t6_acks", acks, 3);
    check("t6_nwr", wr_log.size(), 7);
    check("t6_wr6", wr_log[6], {3'd5, 7'h01, 8'h33});

    // reset during the payload ACK
    i2c_start();
    send_byte(8'h78, a);
    send_byte(8'h40, a);
    send_bits(8'h77, 8);
    wait_clk(Q);
    check("t7_oe_mid_ack", sda_oe, 1);
    rst = 1'b0;
    wait_clk(1);
    check("t7_oe", sda_oe, 0);
    check("t7_page", wr_page, 0);
    check("t7_col", wr_col, 0);
    check("t7_busy", busy, 0);
    check("t7_nwr", wr_log.size(), 8);
    check("t7_wr7", wr_log[7], {3'd5, 7'h02, 8'h77});
    rst = 1'b1;
    sda_drv = 1'b1;
    scl = 1'b1;
    wait_clk(2 * Q);
    check("t7_idle_wr_en", wr_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
